gpio_pad_ctrl: RTL and testbench

//   Core-side controller for the bidirectional pad bank: drives bidir_out/bidir_oe into the
//   pad cells and consumes bidir_in coming back from them. Pad inputs are synchronised,

---
 rtl/gpio_pad_ctrl.sv | 150 +++++++++++++++
 tb/tb_gpio_pad_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad_ctrl.sv
// Core-side controller for the bidirectional pad bank: output/enable registers, synchronised
// and glitch-filtered pad inputs, edge capture with interrupt, and a simple register port.
module gpio_pad_ctrl #(
   parameter int NUM_BIDIR_PADS = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_CYCLES  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_BIDIR_PADS-1:0] bidir_in,
   output logic [NUM_BIDIR_PADS-1:0] bidir_out,
   output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
   input  logic                      reg_valid,
   input  logic                      reg_write,
   input  logic [2:0]                reg_addr,
   input  logic [31:0]               reg_wdata,
   output logic [31:0]               reg_rdata,
   output logic                      reg_rvalid,
   output logic                      irq
);

   localparam int N  = NUM_BIDIR_PADS;
   localparam int CW = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;

   typedef enum logic [2:0] {
      A_DATA_OUT    = 3'd0,
      A_DATA_OE     = 3'd1,
      A_DATA_IN     = 3'd2,
      A_RISE_EN     = 3'd3,
      A_FALL_EN     = 3'd4,
      A_EDGE_STATUS = 3'd5,
      A_IRQ_EN      = 3'd6,
      A_RSVD        = 3'd7
   } addr_e;

   logic [SYNC_STAGES-1:0][N-1:0] sync_q;
   logic [N-1:0] s, filt, filt_d;
   logic [N-1:0] data_out, data_oe, rise_en, fall_en, edge_status, irq_en;
   logic [N-1:0] data_out_nx, data_oe_nx, rise_en_nx, fall_en_nx, edge_nx, irq_en_nx;
   logic [N-1:0] w1c, rise, fall, wdata_n;
   logic [31:0]  rd_mux;
   logic         wr_en;
   logic         wdata_unused;

   assign s            = sync_q[SYNC_STAGES-1];
   assign wdata_n      = reg_wdata[N-1:0];
   assign wdata_unused = ^reg_wdata;
   assign bidir_out    = data_out;
   assign bidir_oe     = data_oe;

   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], bidir_in};
   end

   generate
      if (FILTER_CYCLES == 0) begin : gen_bypass
         always_ff @(posedge clk) begin
            if (rst) filt <= '0;
            else     filt <= s;
         end
      end else begin : gen_filter
         for (genvar p = 0; p < N; p++) begin : gen_pad
            logic [CW-1:0] cnt;
            logic          f;
            // Counter restarts whenever s returns to the filtered value.
            always_ff @(posedge clk) begin
               if (rst) begin
                  cnt <= '0;
                  f   <= 1'b0;
               end else if (s[p] == f) begin
                  cnt <= '0;
               end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
                  f   <= s[p];
                  cnt <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            assign filt[p] = f;
         end
      end
   endgenerate

   always_comb begin
      wr_en       = reg_valid & reg_write;
      data_out_nx = data_out;
      data_oe_nx  = data_oe;
      rise_en_nx  = rise_en;
      fall_en_nx  = fall_en;
      irq_en_nx   = irq_en;
      w1c         = '0;
      if (wr_en) begin
         case (addr_e'(reg_addr))
            A_DATA_OUT:    data_out_nx = wdata_n;
            A_DATA_OE:     data_oe_nx  = wdata_n;
            A_RISE_EN:     rise_en_nx  = wdata_n;
            A_FALL_EN:     fall_en_nx  = wdata_n;
            A_EDGE_STATUS: w1c         = wdata_n;
            A_IRQ_EN:      irq_en_nx   = wdata_n;
            default:       ;
         endcase
      end
      rise    = filt & ~filt_d & rise_en;
      fall    = ~filt & filt_d & fall_en;
      // New edges are OR-ed in after the clear so a coincident edge survives the W1C.
      edge_nx = (edge_status & ~w1c) | rise | fall;
   end

   always_comb begin
      rd_mux = '0;
      case (addr_e'(reg_addr))
         A_DATA_OUT:    rd_mux = 32'(data_out);
         A_DATA_OE:     rd_mux = 32'(data_oe);
         A_DATA_IN:     rd_mux = 32'(filt);
         A_RISE_EN:     rd_mux = 32'(rise_en);
         A_FALL_EN:     rd_mux = 32'(fall_en);
         A_EDGE_STATUS: rd_mux = 32'(edge_status);
         A_IRQ_EN:      rd_mux = 32'(irq_en);
         default:       rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out    <= '0;
         data_oe     <= '0;
         rise_en     <= '0;
         fall_en     <= '0;
         edge_status <= '0;
         irq_en      <= '0;
         filt_d      <= '0;
         irq         <= 1'b0;
         reg_rdata   <= '0;
         reg_rvalid  <= 1'b0;
      end else begin
         data_out    <= data_out_nx;
         data_oe     <= data_oe_nx;
         rise_en     <= rise_en_nx;
         fall_en     <= fall_en_nx;
         edge_status <= edge_nx;
         irq_en      <= irq_en_nx;
         filt_d      <= filt;
         irq         <= |(edge_nx & irq_en_nx);
         reg_rvalid  <= reg_valid & ~reg_write;
         if (reg_valid && !reg_write) reg_rdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Bench for gpio_pad_ctrl: a filtered instance and a filter-bypass instance share the register
// bus; read results are predicted at issue time and compared when reg_rvalid pulses.
module tb_gpio_pad_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  pin, pin_b;
   logic        reg_valid, reg_write;
   logic [2:0]  reg_addr;
   logic [31:0] reg_wdata;

   logic [7:0]  out_m, oe_m, out_b, oe_b;
   logic [31:0] rdata_m, rdata_b;
   logic        rvalid_m, rvalid_b, irq_m, irq_b;

   int total = 0;
   int bad   = 0;

   logic [31:0] q_m[$], q_b[$];
   string       t_m[$], t_b[$];

   always #5 clk = ~clk;

   gpio_pad_ctrl #(.NUM_BIDIR_PADS(8), .SYNC_STAGES(2), .FILTER_CYCLES(4)) u_dut (
      .clk(clk), .rst(rst), .bidir_in(pin), .bidir_out(out_m), .bidir_oe(oe_m),
      .reg_valid(reg_valid), .reg_write(reg_write), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(rdata_m), .reg_rvalid(rvalid_m), .irq(irq_m)
   );

   gpio_pad_ctrl #(.NUM_BIDIR_PADS(8), .SYNC_STAGES(2), .FILTER_CYCLES(0)) u_byp (
      .clk(clk), .rst(rst), .bidir_in(pin_b), .bidir_out(out_b), .bidir_oe(oe_b),
      .reg_valid(reg_valid), .reg_write(reg_write), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(rdata_b), .reg_rvalid(rvalid_b), .irq(irq_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rvalid_m === 1'b1) begin
         if (q_m.size() == 0) check_eq("m_rvalid_unexpected", {31'b0, rvalid_m}, 32'd0);
         else check_eq(t_m.pop_front(), rdata_m, q_m.pop_front());
      end
      if (rvalid_b === 1'b1) begin
         if (q_b.size() == 0) check_eq("b_rvalid_unexpected", {31'b0, rvalid_b}, 32'd0);
         else check_eq(t_b.pop_front(), rdata_b, q_b.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      reg_valid = 1'b1; reg_write = 1'b1; reg_addr = a; reg_wdata = d;
      tick();
      reg_valid = 1'b0; reg_write = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] em, input logic [31:0] eb,
                     input string tag);
      q_m.push_back(em); t_m.push_back({"m_", tag});
      q_b.push_back(eb); t_b.push_back({"b_", tag});
      reg_valid = 1'b1; reg_write = 1'b0; reg_addr = a;
      tick();
      reg_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; pin = '0; pin_b = '0;
      reg_valid = 1'b0; reg_write = 1'b0; reg_addr = '0; reg_wdata = '0;
      repeat (3) tick();
      check_eq("rst_oe",  32'(oe_m),  32'd0);
      check_eq("rst_out", 32'(out_m), 32'd0);
      check_eq("rst_irq", 32'(irq_m), 32'd0);
      check_eq("rst_rvalid", 32'(rvalid_m), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) rd(3'(i), 32'd0, 32'd0, $sformatf("rst_rd%0d", i));

      // Register writes drive the pads on the sampling edge; bits above the pad count drop.
      wr(3'd1, 32'h0000_00F0);
      wr(3'd0, 32'hFFFF_FFA5);
      check_eq("oe_after_wr",  32'(oe_m),  32'h0000_00F0);
      check_eq("out_after_wr", 32'(out_m), 32'h0000_00A5);
      check_eq("b_out_after_wr", 32'(out_b), 32'h0000_00A5);
      rd(3'd0, 32'h0000_00A5, 32'h0000_00A5, "rd_out");
      rd(3'd1, 32'h0000_00F0, 32'h0000_00F0, "rd_oe");
      wr(3'd2, 32'h0000_00FF);
      rd(3'd2, 32'd0, 32'd0, "din_ro");
      wr(3'd7, 32'hFFFF_FFFF);
      rd(3'd7, 32'd0, 32'd0, "rsvd");

      // Pad 3 rises: DATA_IN read sampled 6 edges after the pad sample edge is the first to see it.
      pin[3] = 1'b1;
      for (int j = 0; j < 8; j++)
         rd(3'd2, (j >= 6) ? 32'h08 : 32'h00, 32'd0, $sformatf("din_lat%0d", j));

      pin[2] = 1'b1;
      repeat (3) tick();
      pin[2] = 1'b0;
      repeat (10) tick();
      rd(3'd2, 32'h08, 32'd0, "glitch_din");
      rd(3'd5, 32'h00, 32'd0, "glitch_status");

      wr(3'd3, 32'h01);
      wr(3'd6, 32'h01);
      pin[0] = 1'b1;
      repeat (10) tick();
      check_eq("irq_rise", 32'(irq_m), 32'd1);
      check_eq("b_irq_none", 32'(irq_b), 32'd0);
      rd(3'd5, 32'h01, 32'd0, "status_rise");
      wr(3'd5, 32'h01);
      check_eq("irq_clr", 32'(irq_m), 32'd0);
      rd(3'd5, 32'h00, 32'd0, "status_clr");
      pin[0] = 1'b0;
      repeat (10) tick();
      rd(3'd5, 32'h00, 32'd0, "no_fall");
      check_eq("irq_no_fall", 32'(irq_m), 32'd0);

      wr(3'd4, 32'h08);
      pin[3] = 1'b0;
      repeat (10) tick();
      rd(3'd5, 32'h08, 32'd0, "status_fall");
      check_eq("irq_masked", 32'(irq_m), 32'd0);
      wr(3'd5, 32'h08);
      rd(3'd5, 32'h00, 32'd0, "fall_clr");

      // Status bit0 already set; W1C lands on the edge the next rise is captured.
      pin[0] = 1'b1;
      repeat (10) tick();
      pin[0] = 1'b0;
      repeat (10) tick();
      pin[0] = 1'b1;
      repeat (6) tick();
      wr(3'd5, 32'h01);
      rd(3'd5, 32'h01, 32'd0, "w1c_edge_wins");
      check_eq("irq_edge_wins", 32'(irq_m), 32'd1);
      wr(3'd5, 32'h01);
      rd(3'd5, 32'h00, 32'd0, "w1c_after");

      wr(3'd3, 32'h03);
      pin[1] = 1'b1; pin_b[1] = 1'b1;
      tick();
      pin[1] = 1'b0; pin_b[1] = 1'b0;
      repeat (6) tick();
      rd(3'd5, 32'h00, 32'h02, "pulse1");
      rd(3'd2, 32'h01, 32'h00, "din_final");

      wr(3'd0, 32'h3C);
      wr(3'd1, 32'h0F);
      check_eq("oe_pre_rst", 32'(oe_m), 32'h0F);
      reg_valid = 1'b1; reg_write = 1'b0; reg_addr = 3'd0; rst = 1'b1;
      tick();
      reg_valid = 1'b0;
      check_eq("midrd_rvalid",   32'(rvalid_m), 32'd0);
      check_eq("midrd_b_rvalid", 32'(rvalid_b), 32'd0);
      check_eq("midrd_out",   32'(out_m), 32'd0);
      check_eq("midrd_oe",    32'(oe_m),  32'd0);
      check_eq("midrd_irq",   32'(irq_m), 32'd0);
      check_eq("midrd_rdata", rdata_m, 32'd0);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check_eq("m_queue_empty", 32'(q_m.size()), 32'd0);
      check_eq("b_queue_empty", 32'(q_b.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
